// File: rtl/rsa_ctrl_seq.sv
// rsa_ctrl_seq: start/stop arbitration, operand snapshot and core sequencing.
// Optional RUN watchdog enabled by defining RSA_CTRL_TIMEOUT_EN.
module rsa_ctrl_seq #(
  parameter int WIDTH          = 8,
  parameter int NUM_SRC        = 2,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NUM_SRC-1:0] start_req,
  input  logic [NUM_SRC-1:0] stop_req,
  input  logic [WIDTH-1:0]   p_in,
  input  logic [WIDTH-1:0]   e_in,
  input  logic [WIDTH-1:0]   m_in,
  input  logic [WIDTH-1:0]   const_in,
  input  logic               irq_clr,
  output logic               core_en,
  output logic               core_rstb,
  output logic [WIDTH-1:0]   core_p,
  output logic [WIDTH-1:0]   core_e,
  output logic [WIDTH-1:0]   core_m,
  output logic [WIDTH-1:0]   core_const,
  input  logic               core_eoc,
  input  logic [WIDTH-1:0]   core_c,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               irq,
  output logic [1:0]         status
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_DONE = 2'b01;
  localparam logic [1:0] ST_STOP = 2'b10;
  localparam logic [1:0] ST_TOUT = 2'b11;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);

  logic [1:0]     state;
  logic [RCW-1:0] rcnt;
  logic           start;
  logic           stop;
  logic           wd_hit;

  assign start = |start_req;
  assign stop  = |stop_req;

  assign core_en   = (state == S_RUN);
  assign core_rstb = (state == S_RUN);
  assign busy      = (state != S_IDLE);

`ifdef RSA_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd;

  assign wd_hit = (wd == WD_LAST);

  // Watchdog: cleared while in CLR, counts every enabled RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd <= '0;
    end else if (ena) begin
      if (state == S_CLR) begin
        wd <= '0;
      end else if (state == S_RUN) begin
        wd <= wd + 1'b1;
      end
    end
  end
`else
  // Watchdog compiled out: a timeout can never fire.
  assign wd_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Sequencer FSM plus snapshot, result and irq/status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rcnt       <= '0;
      core_p     <= '0;
      core_e     <= '0;
      core_m     <= '0;
      core_const <= '0;
      result     <= '0;
      irq        <= 1'b0;
      status     <= ST_NONE;
    end else if (ena) begin
      if (irq_clr) begin
        irq    <= 1'b0;
        status <= ST_NONE;
      end
      unique case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state      <= S_CLR;
            rcnt       <= '0;
            core_p     <= p_in;
            core_e     <= e_in;
            core_m     <= m_in;
            core_const <= const_in;
            irq        <= 1'b0;
            status     <= ST_NONE;
          end
        end
        S_CLR: begin
          if (stop) begin
            state  <= S_IDLE;
            status <= ST_STOP;
            irq    <= 1'b1;
          end else if (rcnt == RC_LAST) begin
            state <= S_RUN;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        S_RUN: begin
          if (core_eoc) begin
            state  <= S_IDLE;
            result <= core_c;
            status <= ST_DONE;
            irq    <= 1'b1;
          end else if (stop) begin
            state  <= S_IDLE;
            status <= ST_STOP;
            irq    <= 1'b1;
          end else if (wd_hit) begin
            state  <= S_IDLE;
            status <= ST_TOUT;
            irq    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_ctrl_seq.sv
// tb_rsa_ctrl_seq: randomized scoreboard bench for rsa_ctrl_seq.
// Expected completion records are queued at start; a monitor checks exits.
module tb_rsa_ctrl_seq;

  localparam int W  = 8;
  localparam int NS = 2;
  localparam int RC = 2;
  localparam int TO = 16;
`ifdef RSA_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          ena;
  logic [NS-1:0] start_req;
  logic [NS-1:0] stop_req;
  logic [W-1:0]  p_in;
  logic [W-1:0]  e_in;
  logic [W-1:0]  m_in;
  logic [W-1:0]  const_in;
  logic          irq_clr;
  logic          core_en;
  logic          core_rstb;
  logic [W-1:0]  core_p;
  logic [W-1:0]  core_e;
  logic [W-1:0]  core_m;
  logic [W-1:0]  core_const;
  logic          core_eoc;
  logic [W-1:0]  core_c;
  logic [W-1:0]  result;
  logic          busy;
  logic          irq;
  logic [1:0]    status;

  rsa_ctrl_seq #(
    .WIDTH(W), .NUM_SRC(NS),
    .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .start_req(start_req), .stop_req(stop_req),
    .p_in(p_in), .e_in(e_in), .m_in(m_in),
    .const_in(const_in), .irq_clr(irq_clr),
    .core_en(core_en), .core_rstb(core_rstb),
    .core_p(core_p), .core_e(core_e),
    .core_m(core_m), .core_const(core_const),
    .core_eoc(core_eoc), .core_c(core_c),
    .result(result), .busy(busy),
    .irq(irq), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] st;
    logic [7:0] res;
    logic       irq;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [7:0] m_result;
  logic       prev_busy = 1'b0;

  // Monitor: every busy 1->0 transition consumes one expected record.
  always @(negedge clk) begin
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_exit", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("exit_status", status, mon_e.st);
        chk("exit_result", result, mon_e.res);
        chk("exit_irq", irq, mon_e.irq);
        chk("exit_rstb", core_rstb, 0);
      end
    end
    prev_busy = busy;
  end

  function automatic logic [63:0] outs();
    return {core_en, core_rstb, busy, irq, status, result,
            core_p, core_e, core_m, core_const};
  endfunction

  task automatic clear_in();
    start_req = '0;
    stop_req  = '0;
    core_eoc  = 1'b0;
    irq_clr   = 1'b0;
  endtask

  // One operation; eoc/stop/clr/freeze/rst are RUN-cycle numbers (0 = none),
  // stop_at < 0 aborts during CLR.
  task automatic op(input logic [1:0] src, input logic [7:0] p,
                    input logic [7:0] cv, input int eoc_at,
                    input int stop_at, input int clr_at,
                    input int frz_at, input int rst_at, input bit pchg);
    logic [7:0]  e_v, m_v, k_v;
    logic [63:0] snap;
    int          ex, lim;
    exp_t        x;
    e_v = 8'($urandom);
    m_v = 8'($urandom);
    k_v = 8'($urandom);
    ex = 1 << 30;
    if (eoc_at > 0) ex = eoc_at;
    if (stop_at > 0 && stop_at < ex) ex = stop_at;
    if (TO_EN && TO < ex) ex = TO;
    lim = ex;
    if (stop_at < 0) begin
      x.st = 2'b10; x.res = m_result; x.irq = 1'b1;
    end else if (rst_at > 0 && rst_at <= ex) begin
      x.st = 2'b00; x.res = 8'h00; x.irq = 1'b0;
      lim = rst_at;
    end else if (eoc_at > 0 && eoc_at == ex) begin
      x.st = 2'b01; x.res = cv; x.irq = 1'b1;
    end else if (stop_at == ex) begin
      x.st = 2'b10; x.res = m_result; x.irq = 1'b1;
    end else begin
      x.st = 2'b11; x.res = m_result; x.irq = 1'b1;
    end
    m_result = x.res;
    q.push_back(x);
    @(negedge clk);
    clear_in();
    p_in = p; e_in = e_v; m_in = m_v; const_in = k_v;
    start_req = src;
    @(negedge clk);
    clear_in();
    chk("clr_busy", busy, 1);
    chk("clr_en", core_en, 0);
    chk("clr_rstb", core_rstb, 0);
    chk("clr_irq", irq, 0);
    chk("clr_status", status, 0);
    chk("snap", {core_p, core_e, core_m, core_const},
        {p, e_v, m_v, k_v});
    if (stop_at < 0) begin
      stop_req = 2'b01;
      @(negedge clk);
      clear_in();
      chk("clrstop_en", core_en, 0);
      return;
    end
    repeat (RC - 1) begin
      @(negedge clk);
      chk("clr_hold_en", core_en, 0);
      chk("clr_hold_busy", busy, 1);
    end
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk);
      clear_in();
      chk("run_en", core_en, 1);
      chk("run_rstb", core_rstb, 1);
      if (n == frz_at) begin
        ena  = 1'b0;
        snap = outs();
        repeat (5) begin
          @(negedge clk);
          chk("frozen", outs(), snap);
        end
        ena = 1'b1;
      end
      if (pchg && n == 2) begin
        p_in = 8'hFF;
        start_req = 2'b10;
      end
      if (pchg && n == 3) chk("snap_hold_p", core_p, p);
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outs", outs(), 64'h0);
        return;
      end
      core_c = 8'($urandom);
      if (n == eoc_at) begin
        core_eoc = 1'b1;
        core_c = cv;
      end
      if (n == stop_at) stop_req = 2'($urandom_range(1, 3));
      if (n == clr_at) irq_clr = 1'b1;
    end
    @(negedge clk);
    clear_in();
    chk("exit_en", core_en, 0);
    chk("exit_busy", busy, 0);
    chk("exit_snap_p", core_p, p);
  endtask

  task automatic clr_irq();
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("irqclr_irq", irq, 0);
    chk("irqclr_status", status, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; ena = 1'b1;
    clear_in();
    p_in = '0; e_in = '0; m_in = '0; const_in = '0;
    core_c = '0;
    m_result = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 64'h0);
    rst = 1'b0;

    op(2'b01, 8'h0B, 8'h40, 10, 0, 0, 0, 0, 0);
    clr_irq();
    op(2'b01, 8'h0B, 8'h33, 8, 0, 0, 0, 0, 1);
    op(2'b10, 8'h21, 8'h77, 0, 3, 0, 0, 0, 0);

    @(negedge clk);
    start_req = 2'b01; stop_req = 2'b01;
    @(negedge clk);
    clear_in();
    chk("ss_idle_busy", busy, 0);
    chk("ss_idle_irq", irq, 1);
    chk("ss_idle_status", status, 2'b10);
    stop_req = 2'b10;
    @(negedge clk);
    clear_in();
    chk("stop_idle_busy", busy, 0);
    clr_irq();

    op(2'b01, 8'h5A, 8'h99, 5, 5, 5, 0, 0, 0);
    op(2'b11, 8'h3C, 8'h11, 0, -1, 0, 0, 0, 0);
    op(2'b01, 8'h44, 8'h22, 0, 105, 0, 0, 0, 0);
    op(2'b01, 8'h66, 8'h55, 12, 0, 0, 4, 0, 0);
    op(2'b10, 8'h67, 8'h56, 0, 40, 0, 10, 0, 0);
    op(2'b01, 8'h12, 8'h34, 20, 0, 0, 0, 4, 0);

    for (int k = 0; k < 40; k++) begin
      int ea, sa;
      ea = int'($urandom_range(1, 24));
      sa = 0;
      if ($urandom_range(0, 3) == 0) sa = -1;
      else if ($urandom_range(0, 1) == 1) sa = int'($urandom_range(1, 24));
      op(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom),
         ea, sa, int'($urandom_range(0, 24)), 0, 0, 0);
      if ($urandom_range(0, 1) == 1) clr_irq();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rsa_ctrl_seq.md
Name: rsa_ctrl_seq

Overview:
Parametrised sequencer for the RSA core, successor to the plain enable/EOC controller. It does the following:
- Arbitrates start/stop pulses from NUM_SRC command sources (GPIO, SPI, ...).
- Snapshots the P/E/M/Const operands at start, so SPI writes mid-operation cannot corrupt a run.
- Sequences core reset, enable and completion.
- Latches the result C and raises a sticky IRQ with a completion status code.

It sits between the SPI/GPIO wrappers and rsa_unit inside the top-level.

Parameters:
WIDTH, 8, operand/result width in bits
NUM_SRC, 2, number of start/stop command sources
RST_CYCLES, 2, cycles core_rstb is held low before enabling the core (min 1)
TIMEOUT_CYCLES, 1024, RUN-state watchdog limit in cycles (used only with RSA_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ena  in  1  design enable; low freezes the FSM and all registers
start_req  in  NUM_SRC  per-source start pulses, OR-reduced
stop_req  in  NUM_SRC  per-source stop pulses, OR-reduced
p_in, e_in, m_in, const_in  in  WIDTH each  operand sources from the register file
irq_clr  in  1  clears irq and status
core_en  out  1  enable to rsa_unit
core_rstb  out  1  active-low reset to rsa_unit
core_p, core_e, core_m, core_const  out  WIDTH each  snapshot operands to the core
core_eoc  in  1  core end-of-computation
core_c  in  WIDTH  core result
result  out  WIDTH  latched C
busy  out  1  high in CLR or RUN
irq  out  1  sticky completion interrupt
status  out  2  00 none, 01 done, 10 aborted by stop, 11 timeout

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - core_en=0, core_rstb=0, busy=0, irq=0, status=00, result=0, snapshots=0, counters=0.
- ena=0: no register updates; every output holds its value. Takes precedence over every event except rst.
- IDLE:
  - Outputs: core_en=0, core_rstb=0.
  - Transition: |start_req & ~|stop_req → CLR.
  - On that edge: latch p_in/e_in/m_in/const_in into core_*, clear irq, set status=00, load rst counter=0.
  - Start and stop together in IDLE: stop wins, start dropped. Stop alone: ignored.
- CLR:
  - Outputs: core_rstb=0, core_en=0, busy=1.
  - Counter increments each cycle; after RST_CYCLES cycles → RUN, clear watchdog.
  - Stop during CLR → IDLE, status=10, irq=1.
- RUN:
  - Outputs: core_rstb=1, core_en=1, busy=1; watchdog increments.
  - Same-cycle priority: core_eoc > stop > timeout.
  - core_eoc=1: result<=core_c, status=01, irq=1, → IDLE.
  - Stop: status=10, irq=1, → IDLE; result unchanged.
- Start pulses while busy: ignored, not queued.
- Latency: start sampled at edge t → busy=1 after t. core_en=1 after edge t+RST_CYCLES. irq/result valid after the edge that samples core_eoc.
- Core reset on exit: returning to IDLE reasserts core_rstb=0 in the next cycle.
- irq_clr: clears irq and status to 00. A same-edge completion/abort set wins over irq_clr.
- Snapshot stability: operands never change outside the IDLE→CLR edge.
- Synchronous rst mid-RUN: immediate return to IDLE with reset values; no irq.

Optional Feature:
RSA_CTRL_TIMEOUT_EN:
- Defined:
  - The watchdog counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide.
  - RUN exits to IDLE with status=11, irq=1 when the count reaches TIMEOUT_CYCLES without eoc/stop.
- Undefined:
  - No watchdog logic; RUN waits indefinitely; status 11 is never produced.

Test Plan:
(WIDTH=8, NUM_SRC=2, RST_CYCLES=2, TIMEOUT_CYCLES=16)
- Normal run: start_req=01, P=0x0B E=0x03 M=0x04 Const=0x..; core_eoc after 10 RUN cycles with core_c=0x40 → busy 1 then 0, core_en high 10 cycles, result=0x40, irq=1, status=01; irq_clr → irq=0, status=00.
- Snapshot hold: start, then change p_in to 0xFF during RUN → core_p stays 0x0B until next start.
- Abort: start_req=10, stop_req=01 at RUN cycle 3 → IDLE, status=10, irq=1, result unchanged, core_rstb=0 next cycle. Start+stop same cycle in IDLE → stays IDLE, no irq.
- Priority: core_eoc and stop same RUN cycle → status=01, result latched. irq_clr coincident with eoc → irq=1.
- Timeout (macro on): no eoc → exit after 16 RUN cycles, status=11, irq=1. Macro off: core_en stays high ≥100 cycles.
- ena low for 5 cycles mid-RUN → all outputs frozen, watchdog paused; rst=1 mid-RUN → all reset values next cycle, irq=0.
